// File: rtl/cross_bar_pkg.sv
// Shared crossbar constants: master count and derived index width.
package cross_bar_pkg;

  localparam int MASTER_N = 4;
  localparam int MASTER_W = $clog2(MASTER_N);

endpackage

// File: rtl/cross_bar_rr_arbiter_if.sv
// Request/grant bundle between the masters and the round-robin arbiter.
interface cross_bar_rr_arbiter_if;
  import cross_bar_pkg::*;

  logic [MASTER_N-1:0] req;
  logic [MASTER_N-1:0] grant;

  modport master (output req, input grant);
  modport slave  (input req, output grant);

endinterface

// File: rtl/cross_bar_rr_pick.sv
// Combinational rotating-priority picker: first requester after `last`, circularly.
module cross_bar_rr_pick
  import cross_bar_pkg::*;
(
  input  logic [MASTER_N-1:0] req_i,
  input  logic [MASTER_W-1:0] last_i,
  output logic [MASTER_N-1:0] pick_o,
  output logic [MASTER_W-1:0] pick_idx_o,
  output logic                pick_valid_o
);

  // Scan last+1 .. last+MASTER_N so the previous owner is considered last.
  always_comb begin
    pick_o       = '0;
    pick_idx_o   = '0;
    pick_valid_o = 1'b0;
    for (int k = 1; k <= MASTER_N; k++) begin
      int j;
      j = (int'(last_i) + k) % MASTER_N;
      if (!pick_valid_o && req_i[j]) begin
        pick_valid_o = 1'b1;
        pick_idx_o   = MASTER_W'(j);
        pick_o[j]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cross_bar_rr_arbiter.sv
// Round-robin arbiter: holds a grant while the owner requests, then passes it on.
module cross_bar_rr_arbiter
  import cross_bar_pkg::*;
(
  input  logic                   clk,
  input  logic                   aresetn,
  cross_bar_rr_arbiter_if.slave  bus
);

  logic [MASTER_N-1:0] grant_q, grant_d;
  logic [MASTER_W-1:0] last_q, last_d;
  logic [MASTER_N-1:0] pick;
  logic [MASTER_W-1:0] pick_idx;
  logic                pick_valid;
  logic                hold;

  cross_bar_rr_pick u_pick (
    .req_i        (bus.req),
    .last_i       (last_q),
    .pick_o       (pick),
    .pick_idx_o   (pick_idx),
    .pick_valid_o (pick_valid)
  );

  // Grant is one-hot, so any overlap with req means the owner still requests.
  assign hold = |(grant_q & bus.req);

  always_comb begin
    grant_d = '0;
    last_d  = last_q;
    if (hold) begin
      grant_d = grant_q;
    end else if (pick_valid) begin
      grant_d = pick;
      last_d  = pick_idx;
    end
  end

  // aresetn is active-high despite its name.
  always_ff @(posedge clk or posedge aresetn) begin
    if (aresetn) begin
      grant_q <= '0;
      last_q  <= MASTER_W'(MASTER_N - 1);
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant = grant_q;

endmodule

// File: tb/tb_cross_bar_rr_arbiter.sv
// Bench for cross_bar_rr_arbiter: directed scenarios plus a random soak vs a reference model.
module tb_cross_bar_rr_arbiter;
  import cross_bar_pkg::*;

  logic clk;
  logic aresetn;
  int   n_vec;
  int   n_err;

  int   m_owner;
  int   m_last;

  cross_bar_rr_arbiter_if bus ();

  cross_bar_rr_arbiter dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = MASTER_N - 1;
  endtask

  task automatic model_step(input logic [MASTER_N-1:0] r);
    if (!(m_owner >= 0 && r[m_owner])) begin
      m_owner = -1;
      for (int k = 1; k <= MASTER_N; k++) begin
        int j;
        j = (m_last + k) % MASTER_N;
        if (m_owner < 0 && r[j]) m_owner = j;
      end
      if (m_owner >= 0) m_last = m_owner;
    end
  endtask

  function automatic logic [MASTER_N-1:0] model_grant();
    logic [MASTER_N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // Drive req on the falling edge, sample grant just after the next rising edge.
  task automatic step(input logic [MASTER_N-1:0] r, input string tag);
    @(negedge clk);
    bus.req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check(tag, 32'(bus.grant), 32'(model_grant()));
    check({tag, "_onehot0"}, 32'($onehot0(bus.grant)), 32'd1);
    check({tag, "_gnt_req"}, 32'(bus.grant & ~r), 32'd0);
  endtask

  task automatic step_exp(input logic [MASTER_N-1:0] r, input logic [MASTER_N-1:0] exp,
                          input string tag);
    step(r, tag);
    check({tag, "_lit"}, 32'(bus.grant), 32'(exp));
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    bus.req = '1;
    aresetn = 1'b1;
    model_reset();

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("reset_grant", 32'(bus.grant), 32'd0);
    end
    @(negedge clk);
    aresetn = 1'b0;
    bus.req = '0;

    step_exp(4'b0000, 4'b0000, "idle_after_reset");
    step_exp(4'b1111, 4'b0001, "simul_req");
    for (int i = 0; i < 10; i++) step_exp(4'b1111, 4'b0001, "hold0");
    step_exp(4'b1110, 4'b0010, "release0");
    step_exp(4'b1100, 4'b0100, "release1");
    step_exp(4'b1110, 4'b0100, "nonowner_ignored");
    step_exp(4'b1010, 4'b1000, "skip_to3");
    step_exp(4'b0010, 4'b0010, "wrap_to1");
    step_exp(4'b0000, 4'b0000, "idle");
    step_exp(4'b0001, 4'b0001, "idle_to0");

    // Reset mid-ownership must clear grant without a clock edge.
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("async_reset_clear", 32'(bus.grant), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_clear", 32'(bus.grant), 32'd0);
    @(negedge clk);
    aresetn = 1'b0;
    model_reset();
    step_exp(4'b0110, 4'b0010, "post_reset_prio");

    for (int i = 0; i < 10000; i++) begin
      logic [MASTER_N-1:0] r;
      r = MASTER_N'($urandom);
      if ($urandom_range(0, 3) != 0 && m_owner >= 0) r[m_owner] = 1'b1;
      if ($urandom_range(0, 15) == 0) r = '0;
      step(r, "soak");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cross_bar_rr_arbiter.md
# cross_bar_rr_arbiter

Round-robin arbiter used inside the crossbar to grant one of `MASTER_N` masters access to a shared slave port. It holds a grant for as long as the owning master keeps its request asserted. On release, it passes ownership to the next requesting master in circular order after the previous owner. Grant is registered, one-hot or all-zero.

## Interface
- `MASTER_N`, default 4 (from `cross_bar_pkg`): number of requesting masters, ≥ 2.
- `clk`  input  1  single clock domain; all state updates on the rising edge.
- `aresetn`  input  1  reset, asynchronous, active-high (1 = reset asserted).
- `req`  input  `MASTER_N`  request vector, bit i = master i requests; level-sensitive.
- `grant`  output  `MASTER_N`  registered grant vector; one-hot (bit i = master i owns the port) or all-zero.

## Operation
- State: `grant` register plus `last` pointer (index of the most recent owner, width `$clog2(MASTER_N)`).
- Next-grant rule, evaluated every cycle:
  - **Hold:** if the current owner i still has `req[i]`=1, grant stays on i. There is no timeout or preemption.
  - **Pass:** if there is no owner, or the owner's `req` is 0, pick the first index j with `req[j]`=1, scanning `last+1`, `last+2`, … modulo `MASTER_N`. The previous owner is checked last.
  - **Idle:** if no `req` bit is set, `grant` = 0.
- `last` updates to j whenever a new grant is issued. It is unchanged while holding or idle.
- Wrap-around: after index `MASTER_N-1` the scan continues at 0.
- The owner dropping `req` while others request hands over in the same edge. There is no idle cycle between owners.
- The owner dropping `req` and re-asserting it before the next edge counts as holding; only the sampled value matters.
- A new `req` from a non-owner while the owner holds has no effect until the owner releases.
- Invariant: `grant` is never multi-hot, and `grant[i]`=1 implies `req[i]` was 1 at the sampling edge.

## Timing
- Reset value: `grant` = 0 and `last` = `MASTER_N-1`, so master 0 has top priority after reset.
- Reset assertion clears `grant` and `last` immediately, without waiting for a clock edge, even mid-ownership.
- After reset deasserts, the first grant can appear on the first rising edge at which any `req` is sampled high.
- Latency from `req` to `grant` is 1 cycle when the port is free.
- Latency from the owner releasing `req` to `grant` moving (or clearing) is 1 cycle.
- `grant` changes only on rising edges of `clk`, apart from asynchronous reset.
- `req` is assumed synchronous to `clk`.

## Structure
- `cross_bar_pkg` provides `MASTER_N` (4) and derived `MASTER_W = $clog2(MASTER_N)`. The package is shared with the rest of the crossbar.
- One sub-module is natural: `cross_bar_rr_pick`, a combinational rotating-priority picker.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `pick`, `pick_idx`, `pick_valid`.
  - Implementation: double-width rotate or masked priority encode.
- The top level holds the `grant`/`last` registers and the hold/pass mux.

## Test plan
- **Reset:** `aresetn`=1 with `req`=4'b1111 → `grant`=4'b0000 for the whole reset. Asserting reset mid-grant clears `grant` before the next edge.
- **Simultaneous requests:** after reset, `req` goes 0→4'b1111 in one cycle → next edge `grant`=4'b0001 and stays there while `req[0]` is held for 10+ cycles.
- **Sequential release:** drop `req[0]` → `grant`=4'b0010 one cycle later; drop `req[1]` → 4'b0100.
- **Wrap and skip:** re-raise `req[1]`, then drop `req[2]` → `grant`=4'b1000. Drop `req[3]` → `grant`=4'b0010, wrapping past the idle master 0.
- **Idle:** drop `req[1]` with `req`=0 → `grant`=4'b0000. Then `req`=4'b0001 → `grant`=4'b0001 after 1 cycle.
- **Fairness soak:** random `req` for 10k cycles → `grant` always one-hot or zero, `grant[i]` implies `req[i]` was high at the sampling edge, and hold and round-robin order are checked against a reference model.
